bp_btb: RTL

- Fetch-side branch predictor: a 2-bit-counter BHT plus a direct-mapped BTB.
- Accepts one fetch PC per cycle and returns a registered taken/target prediction one cycle later, which the fetch unit forwards down the pipe as bp/bt.
- Consumes the branch resolution bus driven by the integer pipeline (ip_if_*) to train counters and BTB entries.

---
 rtl/bp_btb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bp_btb.sv
// Fetch branch predictor: 2-bit counter BHT plus direct-mapped BTB.
// Optional BP_STATS_EN builds branch/mispredict debug counters.
module bp_btb #(
  parameter int BHT_ENTRIES  = 256,
  parameter int BTB_ENTRIES  = 32,
  parameter int BTB_TAG_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] if_bp_pc,
  input  logic        if_bp_req,
  input  logic        if_bp_stall,
  output logic        bp_if_ready,
  output logic        bp_if_valid,
  output logic        bp_if_taken,
  output logic [63:0] bp_if_target,
  input  logic        ip_if_branch,
  input  logic        ip_if_branch_taken,
  input  logic [63:0] ip_if_branch_pc,
  input  logic        ip_if_pc_override,
  input  logic [63:0] ip_if_new_pc,
  output logic [63:0] bp_dbg_branches,
  output logic [63:0] bp_dbg_mispredicts
);

  localparam int BHT_IW = $clog2(BHT_ENTRIES);
  localparam int BTB_IW = $clog2(BTB_ENTRIES);
  localparam int SWEEP  = (BHT_ENTRIES > BTB_ENTRIES) ?
                          BHT_ENTRIES : BTB_ENTRIES;
  localparam int SW_IW  = $clog2(SWEEP);
  localparam int TW     = BTB_TAG_BITS;

  typedef enum logic {INIT, RUN} state_t;

  state_t state, state_nxt;
  logic [SW_IW-1:0] sweep_idx, sweep_nxt;

  logic [1:0]           bht [BHT_ENTRIES];
  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TW-1:0]        btb_tag [BTB_ENTRIES];
  logic [63:0]          btb_tgt [BTB_ENTRIES];

  logic [BHT_IW-1:0] rd_bht, wr_bht;
  logic [BTB_IW-1:0] rd_btb, wr_btb;
  logic [TW-1:0]     rd_tag, wr_tag;
  logic              btb_hit, pred_taken;
  logic [63:0]       pred_target;
  logic [1:0]        cnt_cur, cnt_upd;
  logic              run, upd;

  assign run = (state == RUN);
  assign upd = run && ip_if_branch;
  assign bp_if_ready = run;

  assign rd_bht = if_bp_pc[BHT_IW+1:2];
  assign rd_btb = if_bp_pc[BTB_IW+1:2];
  assign rd_tag = if_bp_pc[BTB_IW+2 +: TW];
  assign wr_bht = ip_if_branch_pc[BHT_IW+1:2];
  assign wr_btb = ip_if_branch_pc[BTB_IW+1:2];
  assign wr_tag = ip_if_branch_pc[BTB_IW+2 +: TW];

  // Reads see array contents before this edge's update (no bypass)
  assign btb_hit     = btb_valid[rd_btb] && (btb_tag[rd_btb] == rd_tag);
  assign pred_taken  = btb_hit && bht[rd_bht][1];
  assign pred_target = pred_taken ? btb_tgt[rd_btb] : if_bp_pc + 64'd4;

  assign cnt_cur = bht[wr_bht];

  always_comb begin
    cnt_upd = cnt_cur;
    if (ip_if_branch_taken) begin
      if (cnt_cur != 2'b11) cnt_upd = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_upd = cnt_cur - 2'b01;
    end
  end

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep_idx;
    unique case (1'b1)
      (state == INIT): begin
        sweep_nxt = sweep_idx + 1'b1;
        if (sweep_idx == SW_IW'(SWEEP - 1)) state_nxt = RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_idx <= '0;
    end else begin
      state     <= state_nxt;
      sweep_idx <= sweep_nxt;
    end
  end

  // Storage is not reset; the INIT sweep scrubs it instead
  always_ff @(posedge clk) begin
    if (!run) begin
      bht[sweep_idx[BHT_IW-1:0]]       <= 2'b01;
      btb_valid[sweep_idx[BTB_IW-1:0]] <= 1'b0;
    end else if (upd) begin
      bht[wr_bht] <= cnt_upd;
      if (ip_if_branch_taken) begin
        btb_valid[wr_btb] <= 1'b1;
        btb_tag[wr_btb]   <= wr_tag;
        btb_tgt[wr_btb]   <= ip_if_new_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_if_valid  <= 1'b0;
      bp_if_taken  <= 1'b0;
      bp_if_target <= '0;
    end else if (!if_bp_stall) begin
      if (if_bp_req && run) begin
        bp_if_valid  <= 1'b1;
        bp_if_taken  <= pred_taken;
        bp_if_target <= pred_target;
      end else begin
        bp_if_valid  <= 1'b0;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_dbg_branches    <= '0;
      bp_dbg_mispredicts <= '0;
    end else if (run) begin
      if (ip_if_branch)      bp_dbg_branches    <= bp_dbg_branches + 64'd1;
      if (ip_if_pc_override) bp_dbg_mispredicts <= bp_dbg_mispredicts + 64'd1;
    end
  end
`else
  assign bp_dbg_branches    = '0;
  assign bp_dbg_mispredicts = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{if_bp_pc, ip_if_branch_pc, ip_if_pc_override};

endmodule
